prog_clk_div: RTL
=================

Name: prog_clk_div

Overview:
- Multi-channel, runtime-programmable clock divider. Successor to the fixed 1000 Hz -> 1 Hz divider.
- Each of NUM_CH channels divides the system clock by its own divisor. Each channel produces a near-50% duty square wave (clk_out) and a one-cycle strobe per period (tick).
- Divisors are reprogrammed over a valid/ready config port. Updates apply glitch-free at the channel's period boundary.
- Sits between the system clock and the timekeeping/display logic. Consumers use tick as a clock enable.

Parameters:
- WIDTH, 16, divisor/counter bit width; maximum divisor 2**WIDTH-1.
- NUM_CH, 4, number of independent divider channels.
- CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_CH.
- DIV_DEFAULT, 1000, divisor loaded into every channel at reset.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel count enable.
- sync_all  in  1  restart all channel counters at 0 together (phase alignment).
- cfg_valid  in  1  config request valid.
- cfg_ch  in  CH_W  target channel of the request.
- cfg_div  in  WIDTH  requested divisor.
- cfg_ready  out  1  config request can be accepted.
- cfg_err  out  1  one-cycle pulse: request addressed cfg_ch >= NUM_CH.
- clk_out  out  NUM_CH  divided square wave per channel.
- tick  out  NUM_CH  one-cycle strobe per completed period.
- div_cur  out  NUM_CH*WIDTH  active divisor per channel; channel i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (synchronous, reset=1 at a rising edge), for every channel:
  - cnt=0, div_cur=DIV_DEFAULT, pending=0.
  - clk_out=0, tick=0, cfg_err=0.
  - Reset discards any pending update. Reset mid-period takes effect on that edge.
- Counting: when en[i]=1, cnt counts 0..div_cur-1 and then wraps to 0. When en[i]=0, cnt and clk_out hold and tick=0.
- tick[i]: registered. It is 1 for exactly one cycle, the cycle after the edge on which cnt==div_cur-1 with en[i]=1. Period = div_cur cycles.
- clk_out[i]: registered from the current cnt, so one cycle latency. Value is (cnt >= div_cur>>1).
  - Low for floor(D/2) cycles, high for ceil(D/2) cycles.
  - Example D=5: low 2, high 3.
- Divisor D=1: cnt stays 0, tick=1 every enabled cycle, clk_out held 1.
- cfg_div=0: clamped to 1 on capture.
- Handshake:
  - cfg_ready = !pending[cfg_ch] when cfg_ch < NUM_CH, else 1.
  - Transfer occurs when cfg_valid && cfg_ready at a rising edge.
  - On transfer, shadow[cfg_ch]<=cfg_div (clamped) and pending[cfg_ch]<=1.
  - Requests to cfg_ch >= NUM_CH are accepted, dropped, and pulse cfg_err the next cycle.
- Apply rules:
  - With en[i]=1: a pending update applies on the wrap edge (cnt==div_cur-1). On that edge div_cur<=shadow, cnt<=0, pending<=0. The current period always completes at the old divisor.
  - With en[i]=0: a pending update applies on the next edge and cnt<=0.
- Simultaneous transfer and wrap on the same channel: the value is captured into shadow and applies at the following wrap, never on the same edge.
- sync_all=1: every channel gets cnt<=0 and clk_out<=0, and every pending update applies immediately. tick=0 that cycle. reset has priority over sync_all.
- Arithmetic: cnt and div_cur are WIDTH bits and the compare is unsigned. A divisor of 2**WIDTH-1 must not overflow.

Decomposition:
- Shared package prog_clk_div_pkg holds:
  - default-divisor constant;
  - clamp-to-1 function;
  - slice helper for the packed div_cur bus.
- One sub-module, div_channel, instantiated NUM_CH times. It contains cnt, div_cur, shadow, pending, clk_out and tick.
- The top level holds the config decode, cfg_ready mux and cfg_err register.

Test Plan:
- Reset then en=1 on ch0 with DIV_DEFAULT=1000 -> tick every 1000 cycles; clk_out low 500, high 500.
- Program ch1 to 5 -> tick period 5; clk_out low 2, high 3; div_cur ch1 = 5 after the first wrap.
- Mid-period write of 4 to ch2 (D=10, cnt=3) -> period completes at 10, then 4. cfg_ready low until the wrap. A second write is stalled until then.
- Write 0 to ch3 -> clamps to 1: tick every cycle, clk_out constant 1. Write to cfg_ch=3 with NUM_CH=3 -> cfg_err pulses one cycle, no state change.
- sync_all asserted with ch0=7 and ch1=3 at mixed phases -> both cnt=0; ticks then coincide every 21 cycles.
- reset asserted mid-period with a pending write -> all outputs return to reset values, the pending update is lost, and div_cur=DIV_DEFAULT.

Source files
------------

// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package prog_clk_div_pkg;

    localparam int unsigned DEF_DIV = 1000;

    // A divisor of 0 has no meaningful period, so it is treated as divide-by-1.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Divisor configuration port: valid/ready request plus an error pulse for bad channel indices.
interface prog_clk_div_if #(
    parameter int CH_W  = 2,
    parameter int WIDTH = 16
);
    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/prog_clk_div_channel.sv
// One divider channel: up-counter with wrap compare, shadowed divisor applied at the period boundary.
module div_channel
    import prog_clk_div_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int unsigned DIV_DEFAULT = DEF_DIV
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic [WIDTH-1:0] div_cur
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic             wrap;

    // div_cur is never 0, so div_cur-1 cannot underflow and cnt+1 never passes div_cur-1.
    assign wrap = (cnt == div_cur - ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            div_cur <= WIDTH'(DIV_DEFAULT);
            shadow  <= WIDTH'(DIV_DEFAULT);
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (sync) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pending) begin
                    div_cur <= shadow;
                    pending <= 1'b0;
                end
            end else if (en) begin
                tick    <= wrap;
                clk_out <= (cnt >= (div_cur >> 1));
                if (wrap) begin
                    cnt <= '0;
                    if (pending) begin
                        div_cur <= shadow;
                        pending <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + ONE;
                end
            end else begin
                tick <= 1'b0;
                if (pending) begin
                    div_cur <= shadow;
                    pending <= 1'b0;
                    cnt     <= '0;
                end
            end
            // A capture on a wrap edge lands after the apply above, so it waits for the next wrap.
            if (wr) begin
                shadow  <= wr_div;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel runtime-programmable clock divider: config decode, ready mux and error pulse.
module prog_clk_div
    import prog_clk_div_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          NUM_CH      = 4,
    parameter int          CH_W        = 2,
    parameter int unsigned DIV_DEFAULT = DEF_DIV
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync_all,
    prog_clk_div_if.slave           cfg,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH*WIDTH-1:0] div_cur
);
    localparam int PAD_CH = 2**CH_W;

    logic [NUM_CH-1:0] pending;
    logic [PAD_CH-1:0] pending_pad;
    logic              ch_valid;
    logic [WIDTH-1:0]  div_clamped;

    // Out-of-range channels never stall; they are accepted and reported via cfg_err.
    assign ch_valid      = (int'(cfg.cfg_ch) < NUM_CH);
    assign pending_pad   = PAD_CH'(pending);
    assign cfg.cfg_ready = ch_valid ? ~pending_pad[cfg.cfg_ch] : 1'b1;
    assign div_clamped   = WIDTH'(clamp_div(32'(cfg.cfg_div)));

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= cfg.cfg_valid && !ch_valid;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(i));

        div_channel #(
            .WIDTH       (WIDTH),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .en      (en[i]),
            .sync    (sync_all),
            .wr      (wr),
            .wr_div  (div_clamped),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i]),
            .div_cur (div_cur[slice_lo(i, WIDTH) +: WIDTH])
        );
    end
endmodule
